// File: rtl/key_cmd_fifo.sv
// Command buffer between the PS/2 key decoder and the game logic.
// Captures one command per decoder handshake into a circular FIFO and counts overflow drops.
module key_cmd_fifo #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_read_fin,
  input  logic                  flush,
  output logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_read_fin,
  output logic [LOG2_DEPTH:0]   count,
  output logic [7:0]            drop_cnt
);

  // state | meaning
  // IDLE  | waiting for in_ready; a command is captured on the edge it is seen high
  // ACK   | in_read_fin asserted; held until the decoder drops in_ready
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } up_state_t;

  localparam logic [LOG2_DEPTH:0]   FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE  = (LOG2_DEPTH + 1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);

  up_state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wp, rp;
  logic                  capture;
  logic                  pop;
  logic                  push;
  logic                  drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!in_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_read_fin = (state == ACK);

  // A full FIFO still accepts a capture when the head leaves on the same edge.
  // Flush wins over everything, and a capture lost to flush is not an overflow.
  assign pop  = out_read_fin && (count != '0);
  assign push = capture && !flush && ((count != FULL_CNT) || pop);
  assign drop = capture && !flush && !push;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_ONE;
      end
      if (pop) begin
        rp <= rp + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign out_ready = (count != '0);
  assign out_data  = mem[rp];

endmodule

// File: tb/tb_key_cmd_fifo.sv
// Bench for key_cmd_fifo: directed scenarios plus random traffic, checked against
// a queue-based model of the command buffer updated once per clock.
module tb_key_cmd_fifo;

  localparam int DW    = 3;
  localparam int DEPTH = 8;
  localparam int LD    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_read_fin;
  logic          flush = 1'b0;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_read_fin = 1'b0;
  logic [LD:0]   count;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  // reference model
  int exp_q[$];
  int exp_drop = 0;
  bit exp_ack  = 1'b0;

  key_cmd_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LOG2_DEPTH(LD)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_read_fin  (in_read_fin),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_read_fin (out_read_fin),
    .count        (count),
    .drop_cnt     (drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model mid-cycle, then advance the model
  // with the inputs that will be sampled on the coming rising edge.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_count", int'(count), 0);
      chk("rst_out_ready", int'(out_ready), 0);
      chk("rst_in_read_fin", int'(in_read_fin), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      exp_q.delete();
      exp_drop = 0;
      exp_ack  = 1'b0;
    end else begin
      chk("count", int'(count), exp_q.size());
      chk("out_ready", int'(out_ready), int'(exp_q.size() != 0));
      chk("in_read_fin", int'(in_read_fin), int'(exp_ack));
      chk("drop_cnt", int'(drop_cnt), exp_drop);
      if (exp_q.size() != 0) begin
        chk("out_data", int'(out_data), exp_q[0]);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_read_fin && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
        end
        if (in_ready && !exp_ack) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(int'(in_data));
          else if (exp_drop < 255) exp_drop++;
        end
      end
      exp_ack = in_ready;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int d, input int hold);
    in_ready = 1'b1;
    in_data  = DW'(d);
    repeat (hold) step();
    in_ready = 1'b0;
    step();
  endtask

  task automatic pop_n(input int n);
    out_read_fin = 1'b1;
    repeat (n) step();
    out_read_fin = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #1;
    do_reset();

    // single command held for several cycles
    send(5, 5);
    chk("t1_count", int'(count), 1);
    chk("t1_out_data", int'(out_data), 5);
    chk("t1_out_ready", int'(out_ready), 1);
    pop_n(1);
    chk("t1_count_after_pop", int'(count), 0);
    chk("t1_ready_after_pop", int'(out_ready), 0);

    // ordering
    for (int i = 1; i <= 4; i++) send(i, 1);
    chk("t2_count", int'(count), 4);
    pop_n(4);
    chk("t2_ready_drained", int'(out_ready), 0);

    // overflow and saturation
    for (int i = 0; i < 8; i++) send(i, 1);
    send(6, 1);
    send(5, 2);
    chk("t3_count_full", int'(count), 8);
    chk("t3_drop", int'(drop_cnt), 2);
    chk("t3_head", int'(out_data), 0);
    for (int i = 0; i < 300; i++) send(i % 8, 1);
    chk("t3_drop_sat", int'(drop_cnt), 255);

    // full with simultaneous pop
    in_ready = 1'b1;
    in_data  = 3'd7;
    out_read_fin = 1'b1;
    step();
    out_read_fin = 1'b0;
    step();
    in_ready = 1'b0;
    step();
    chk("t4_count_full", int'(count), 8);
    chk("t4_drop", int'(drop_cnt), 255);
    pop_n(7);
    chk("t4_last", int'(out_data), 7);
    pop_n(1);
    chk("t4_empty", int'(count), 0);

    // empty pop, then flush against pop and capture
    do_reset();
    pop_n(3);
    chk("t5_empty_pop", int'(count), 0);
    for (int i = 0; i < 3; i++) send(i + 2, 1);
    in_ready = 1'b1;
    in_data  = 3'd4;
    flush = 1'b1;
    out_read_fin = 1'b1;
    step();
    flush = 1'b0;
    out_read_fin = 1'b0;
    chk("t5_flush_count", int'(count), 0);
    chk("t5_flush_ready", int'(out_ready), 0);
    chk("t5_flush_drop", int'(drop_cnt), 0);
    chk("t5_ack_kept", int'(in_read_fin), 1);
    in_ready = 1'b0;
    step();

    // async reset in the middle of a handshake
    for (int i = 0; i < 9; i++) send(i, 1);
    pop_n(6);
    in_ready = 1'b1;
    in_data  = 3'd6;
    step();
    chk("t6_pre_ack", int'(in_read_fin), 1);
    chk("t6_pre_count", int'(count), 3);
    chk("t6_pre_drop", int'(drop_cnt), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_ack", int'(in_read_fin), 0);
    chk("t6_async_count", int'(count), 0);
    chk("t6_async_drop", int'(drop_cnt), 0);
    step();
    reset = 1'b0;
    step();
    chk("t6_recapture_count", int'(count), 1);
    chk("t6_recapture_data", int'(out_data), 6);
    in_ready = 1'b0;
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (in_ready) in_ready = ($urandom_range(0, 2) != 0);
      else          in_ready = ($urandom_range(0, 1) != 0);
      in_data      = DW'($urandom);
      out_read_fin = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 40) == 0);
      step();
    end
    in_ready = 1'b0;
    out_read_fin = 1'b0;
    flush = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
